// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: controller mode encodings, default sizes and the
// decryptor state type.
package rc4_pkg;

    localparam int RAM_WIDTH_DEFAULT  = 8;
    localparam int MSG_LENGTH_DEFAULT = 32;

    // Device-select codes driven by the RAM controller
    localparam logic [2:0] MODE_IDLE    = 3'b000;
    localparam logic [2:0] MODE_INIT    = 3'b001;
    localparam logic [2:0] MODE_SHUFFLE = 3'b010;
    localparam logic [2:0] MODE_DECRYPT = 3'b100;

    typedef enum logic [3:0] {
        IDLE,
        READ_SI,
        WAIT_SI,
        READ_SJ,
        WAIT_SJ,
        WRITE_SI,
        WRITE_SJ,
        READ_F,
        WAIT_F,
        WRITE_OUT,
        DONE
    } decrypt_state_t;

endpackage

// File: rtl/ram_decryptor.sv
// RC4 PRGA engine: walks the S-box, swaps entries, and XORs the keystream
// with ROM ciphertext into the message RAM, one byte every 9 cycles.
module ram_decryptor
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH  = RAM_WIDTH_DEFAULT,
    parameter int MSG_LENGTH = MSG_LENGTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          finished,
    input  logic [RAM_WIDTH-1:0]          s_ram_out,
    output logic                          s_write_enable,
    output logic [RAM_WIDTH-1:0]          s_ram_in,
    output logic [RAM_WIDTH-1:0]          s_address,
    input  logic [RAM_WIDTH-1:0]          rom_out,
    output logic [$clog2(MSG_LENGTH)-1:0] rom_address,
    output logic                          d_write_enable,
    output logic [RAM_WIDTH-1:0]          d_ram_in,
    output logic [$clog2(MSG_LENGTH)-1:0] d_address
);

    localparam int KW = $clog2(MSG_LENGTH);
    localparam logic [KW-1:0] LAST_K = KW'(MSG_LENGTH - 1);

    decrypt_state_t state, next_state;

    logic [RAM_WIDTH-1:0] i, j, si, sj, f, enc;
    logic [RAM_WIDTH-1:0] s_addr_hold;
    logic [KW-1:0]        k;

    // State register plus the datapath registers each state is responsible for
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            si          <= '0;
            sj          <= '0;
            f           <= '0;
            enc         <= '0;
            s_addr_hold <= '0;
        end else begin
            state       <= next_state;
            s_addr_hold <= s_address;
            case (state)
                IDLE: begin
                    if (start) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end
                end
                READ_SI:   i <= i + RAM_WIDTH'(1);
                WAIT_SI: begin
                    si  <= s_ram_out;
                    enc <= rom_out;
                end
                READ_SJ:   j <= j + si;
                WAIT_SJ:   sj <= s_ram_out;
                WAIT_F:    f <= s_ram_out;
                WRITE_OUT: begin
                    if (k != LAST_K) k <= k + KW'(1);
                end
                default: ;
            endcase
        end
    end

    // Outside the read/write states the S-box address keeps its last value
    always_comb begin
        next_state     = state;
        s_address      = s_addr_hold;
        s_ram_in       = '0;
        s_write_enable = 1'b0;
        d_ram_in       = '0;
        d_write_enable = 1'b0;
        finished       = 1'b0;
        case (state)
            IDLE:     if (start) next_state = READ_SI;
            READ_SI: begin
                s_address  = i + RAM_WIDTH'(1);
                next_state = WAIT_SI;
            end
            WAIT_SI:  next_state = READ_SJ;
            READ_SJ: begin
                s_address  = j + si;
                next_state = WAIT_SJ;
            end
            WAIT_SJ:  next_state = WRITE_SI;
            WRITE_SI: begin
                s_address      = i;
                s_ram_in       = sj;
                s_write_enable = 1'b1;
                next_state     = WRITE_SJ;
            end
            WRITE_SJ: begin
                s_address      = j;
                s_ram_in       = si;
                s_write_enable = 1'b1;
                next_state     = READ_F;
            end
            READ_F: begin
                s_address  = si + sj;
                next_state = WAIT_F;
            end
            WAIT_F:   next_state = WRITE_OUT;
            WRITE_OUT: begin
                d_ram_in       = f ^ enc;
                d_write_enable = 1'b1;
                next_state     = (k == LAST_K) ? DONE : READ_SI;
            end
            DONE: begin
                finished = 1'b1;
                if (!start) next_state = IDLE;
            end
            default:  next_state = IDLE;
        endcase
    end

    assign rom_address = k;
    assign d_address   = k;

endmodule

// File: doc/ram_decryptor.md
Name: ram_decryptor

Overview:
- RC4 keystream-generation (PRGA) and decrypt engine; the reading end of the S-box RAM that the initializer and shuffler devices fill.
- Runs as a controller-selected device: takes the start/finished handshake from the RAM controller.
- Reads and swaps S-box bytes, reads ciphertext from ROM, writes XOR-decrypted plaintext to a message RAM.

Parameters:
RAM_WIDTH, 8, byte width and S-box address width (S-box depth = 2^RAM_WIDTH).
MSG_LENGTH, 32, number of message bytes decrypted per run.

Ports:
clk  input  1  single clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  level request from controller; sampled only in IDLE.
finished  output  1  high while in DONE.
s_ram_out  input  RAM_WIDTH  S-box read data.
s_write_enable  output  1  S-box write strobe.
s_ram_in  output  RAM_WIDTH  S-box write data.
s_address  output  RAM_WIDTH  S-box address.
rom_out  input  RAM_WIDTH  ciphertext read data.
rom_address  output  $clog2(MSG_LENGTH)  ciphertext address (= k).
d_write_enable  output  1  plaintext RAM write strobe.
d_ram_in  output  RAM_WIDTH  plaintext byte.
d_address  output  $clog2(MSG_LENGTH)  plaintext address (= k).

Behaviour:
- Reset (sync, any state): state IDLE; i, j, k, si, sj, f, enc registers = 0; all outputs 0. S-box contents are not restored.
- Memory timing: all RAM/ROM reads are synchronous with 1-cycle latency.
  - Address is driven during state A.
  - Data is sampled at the end of the following wait state W.
- Algorithm per byte, all sums mod 2^RAM_WIDTH:
  - i = i+1
  - j = j + S[i]
  - swap S[i] and S[j]
  - f = S[S[i]+S[j]]
  - P[k] = f XOR C[k]
- FSM states and actions (9 cycles per byte):
  - IDLE: start=1 moves to READ_SI with i=0, j=0, k=0.
  - READ_SI: s_address = i+1; i updated on exit; rom_address = k.
  - WAIT_SI: latch si = s_ram_out and enc = rom_out.
  - READ_SJ: s_address = j+si; j updated on exit.
  - WAIT_SJ: latch sj.
  - WRITE_SI: s_address = i, s_ram_in = sj, s_write_enable = 1.
  - WRITE_SJ: s_address = j, s_ram_in = si, s_write_enable = 1.
  - READ_F: s_address = si+sj.
  - WAIT_F: latch f.
  - WRITE_OUT: d_address = k, d_ram_in = f^enc, d_write_enable = 1. If k == MSG_LENGTH-1, go to DONE; else k++ and go to READ_SI.
  - DONE: finished = 1. Stay while start = 1; start = 0 returns to IDLE on the next edge.
- Write strobes are high only in their write states and for exactly one cycle each.
- s_address holds the last driven value otherwise (any stable value is legal).
- i == j: both writes hit the same address with equal data; S is unchanged. This is legal, not special-cased.
- Read-after-write on S (si+sj == i or j): READ_F follows both writes, so post-swap data is returned.
- Run latency: DONE is entered 9*MSG_LENGTH edges after the edge that samples start in IDLE.
- A new run requires start to fall (exit DONE) and rise again.
- start dropping mid-run is ignored; the run completes.

Decomposition:
- Shared package rc4_pkg holds:
  - the state enum type
  - default RAM_WIDTH and MSG_LENGTH constants
  - the controller mode encodings, adding 3'b100 = decrypt
- No sub-module: one FSM plus a small datapath register set in a single module.

Test Plan:
- Reset/idle: assert reset 2 cycles, start = 0 -> finished = 0, all write enables 0, all addresses 0; outputs stay there for 10 cycles.
- Identity S-box (S[x] = x), MSG_LENGTH = 4, C = 00,00,00,00:
  - P = 02,05,07,0D.
  - S afterwards: S[2]=03, S[3]=05, S[4]=09, S[5]=02, S[9]=04; all other entries unchanged.
  - Byte 0 (i = j = 1) shows two writes of 01 to address 1.
- Same S-box, C = FF,FF,00,A5 -> P = FD,FA,07,A8.
- Timing: start sampled at edge 0 -> finished first high after edge 36 (MSG_LENGTH = 4).
  - Exactly 8 s_write_enable pulses and 4 d_write_enable pulses.
  - No writes while in DONE.
- Handshake: hold start high 20 cycles in DONE -> finished stays 1 with no strobes. Drop start -> finished = 0 next cycle. Re-raise -> new run restarts with i = j = k = 0.
- Reset mid-run: assert reset during WRITE_SI of byte 2 -> next cycle IDLE, all strobes 0, finished = 0. A subsequent start completes normally.
